muldiv_unit: RTL and testbench

Iterative 32-bit unsigned multiply/divide unit with HI/LO result registers. It sits in the execute stage beside the 32-bit ALU and takes the same register-file operands `a` and `b`. It serves MULTU, DIVU, MTHI and MTLO. While an iterative operation runs, `busy` stalls the multicycle controller. HI and LO are read back by MFHI/MFLO through the result mux that also takes the ALU result.

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Operand, request and HI/LO result bundle shared by the execute-stage
// controller (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             start;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, start, op,
    input  busy, done, hi, lo
  );

  modport slave (
    input  a, b, start, op,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit with HI/LO registers; one shift-add or
// restoring-divide step per cycle, WIDTH cycles per operation.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic             is_div, is_div_n;
  logic [WIDTH-1:0] acc_hi, acc_hi_n;
  logic [WIDTH-1:0] acc_lo, acc_lo_n;
  logic [WIDTH-1:0] hi_q, hi_n;
  logic [WIDTH-1:0] lo_q, lo_n;
  logic             done_q, done_n;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // One iteration of either algorithm; acc_hi/acc_lo hold {P_hi,P_lo} or {R,Q}.
  always_comb begin
    mul_sum  = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, a_q}) : {1'b0, acc_hi};
    div_rem  = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_rem - {1'b0, b_q};
    step_hi  = '0;
    step_lo  = '0;
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_rem[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    a_n      = a_q;
    b_n      = b_q;
    is_div_n = is_div;
    acc_hi_n = acc_hi;
    acc_lo_n = acc_lo;
    hi_n     = hi_q;
    lo_n     = lo_q;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            2'b00, 2'b01: begin
              a_n      = bus.a;
              b_n      = bus.b;
              is_div_n = bus.op[0];
              acc_hi_n = '0;
              acc_lo_n = bus.op[0] ? bus.a : bus.b;
              count_n  = CW'(WIDTH);
              state_n  = RUN;
            end
            2'b10:   hi_n = bus.a;
            default: lo_n = bus.a;
          endcase
        end
      end
      RUN: begin
        // Requests arriving here are dropped; HI/LO change only on the final step.
        acc_hi_n = step_hi;
        acc_lo_n = step_lo;
        if (count != '0) begin
          count_n = count - CW'(1);
        end
        if (count == CW'(1)) begin
          hi_n    = step_hi;
          lo_n    = step_lo;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      is_div <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      a_q    <= a_n;
      b_q    <= b_n;
      is_div <= is_div_n;
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      done_q <= done_n;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed on issue, popped
// and compared whenever done pulses.
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sbq[$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          doneCount  = 0;
  logic        overlapSeen = 1'b0;
  logic        holdBroken  = 1'b0;
  logic [31:0] hiPrev;
  logic [31:0] loPrev;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b00) return {32'b0, a} * {32'b0, b};
    if (b == 32'b0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Called at a negedge; returns at the following negedge with start dropped.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] r;
    hiPrev    = bus.hi;
    loPrev    = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (op[1] == 1'b0) begin
      r     = model(op, a, b);
      e.tag = tag;
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitBusy(input string tag, input int expCycles);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.hi !== hiPrev || bus.lo !== loPrev) holdBroken = 1'b1;
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_cycles"}, 64'(n), 64'(expCycles));
    checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd1);
  endtask

  task automatic finishOp(input string tag);
    @(negedge clk);
    checkOutput({tag, "_done_clear"}, 64'(bus.done), 64'd0);
  endtask

  // Scoreboard consumer, sampled just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlapSeen = 1'b1;
      if (bus.done === 1'b1) begin
        doneCount++;
        if (sbq.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
          checkOutput({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus("mul_small", 2'b00, 32'h0000_1234, 32'h0000_5678);
    waitBusy("mul_small", 32);
    checkOutput("mul_small_const", {bus.hi, bus.lo}, {32'h0, 32'h0626_0060});
    finishOp("mul_small");

    applyStimulus("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitBusy("mul_max", 32);
    checkOutput("mul_max_const", {bus.hi, bus.lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    finishOp("mul_max");

    applyStimulus("div_100_7", 2'b01, 32'd100, 32'd7);
    waitBusy("div_100_7", 32);
    checkOutput("div_100_7_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
    finishOp("div_100_7");

    applyStimulus("div_by_zero", 2'b01, 32'd5, 32'd0);
    waitBusy("div_by_zero", 32);
    checkOutput("div_by_zero_const", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});
    finishOp("div_by_zero");

    // MTHI then MTLO on consecutive edges
    applyStimulus("mthi", 2'b10, 32'hDEAD_BEEF, 32'h0);
    checkOutput("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    checkOutput("mthi_busy_done", {bus.busy, bus.done}, 64'd0);
    applyStimulus("mtlo", 2'b11, 32'h0BAD_F00D, 32'h0);
    checkOutput("mtlo_lo", 64'(bus.lo), 64'h0BAD_F00D);
    checkOutput("mtlo_hi_kept", 64'(bus.hi), 64'hDEAD_BEEF);
    checkOutput("mtlo_busy_done", {bus.busy, bus.done}, 64'd0);

    // DIVU disturbed by ignored requests and operand changes mid-run
    applyStimulus("div_mid", 2'b01, 32'd1000, 32'd9);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'h5555_5555;
    @(negedge clk);
    bus.op    = 2'b00;
    bus.a     = 32'h0000_1234;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'd1;
    waitBusy("div_mid", 26);
    checkOutput("div_mid_const", {bus.hi, bus.lo}, {32'd1, 32'd111});

    // Back-to-back issue in the done cycle
    applyStimulus("mul_b2b", 2'b00, 32'd7, 32'd9);
    checkOutput("mul_b2b_accepted", {bus.busy, bus.done}, 64'b10);
    waitBusy("mul_b2b", 32);
    checkOutput("mul_b2b_const", {bus.hi, bus.lo}, {32'd0, 32'd63});
    finishOp("mul_b2b");

    // Reset during MULTU: no partial write, no later done
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'h0000_ABCD;
    bus.b     = 32'h0000_1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy_done", {bus.busy, bus.done}, 64'd0);
    checkOutput("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;
    d0 = doneCount;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", 64'(doneCount), 64'(d0));

    checkOutput("busy_done_exclusive", 64'(overlapSeen), 64'd0);
    checkOutput("hilo_held_during_run", 64'(holdBroken), 64'd0);
    checkOutput("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
